// File: rtl/alu_src_pkg.sv
// -----------------------------------------------------------------------------
// alu_src_pkg
// Shared definitions for the ALU operand-source stage and its skid buffer.
//   - skid_state_e  : occupancy of the 2-entry skid buffer
//   - sel_aux_code  : select code that picks the aux hold register
//   - sel_zero_code : select code that picks constant zero
// Codes above sel_zero_code are out of range.
// -----------------------------------------------------------------------------
package alu_src_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

   function automatic int sel_aux_code(input int nsrc);
      return nsrc;
   endfunction

   function automatic int sel_zero_code(input int nsrc);
      return nsrc + 1;
   endfunction

endpackage

// File: rtl/skid_buf.sv
// -----------------------------------------------------------------------------
// skid_buf
// Two-entry valid/ready skid buffer. Data is registered on entry, so there is
// one cycle of latency and no combinational path from out_ready to in_ready.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_data/in_valid      upstream request, in_ready = buffer not FULL
//   out_data/out_valid    head entry, held stable until out_ready
//   out_ready             downstream consumes the head entry
// -----------------------------------------------------------------------------
module skid_buf
   import alu_src_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   skid_state_e   state_q, state_d;
   logic [DW-1:0] head_q, head_d;
   logic [DW-1:0] skid_q, skid_d;
   logic          accept;
   logic          drain;

   // Plain state decodes, so both handshakes are registered signals.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = head_q;

   assign accept = in_valid && in_ready;
   assign drain  = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               head_d  = in_data;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && drain) begin
               // Head leaves and the new entry replaces it in the same cycle.
               head_d = in_data;
            end else if (accept) begin
               skid_d  = in_data;
               state_d = FULL;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so only a drain can happen.
            if (drain) begin
               head_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/alu_src_stage.sv
// -----------------------------------------------------------------------------
// alu_src_stage
// Registered ALU operand selector. Picks one of NSRC external sources, the aux
// hold register, or zero, and passes {sel, value} through a skid buffer.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   src_flat                NSRC packed sources, source i at [i*WIDTH +: WIDTH]
//   sel, hold_en, in_valid  request; hold_en also loads the value into aux
//   in_ready                stage can accept a request
//   out_data/out_sel        operand and the select code that produced it
//   out_valid/out_ready     handshake towards the ALU
//   err_clr/sel_err         sticky out-of-range select flag and its clear
// -----------------------------------------------------------------------------
module alu_src_stage
   import alu_src_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NSRC  = 4,
   parameter int SELW  = $clog2(NSRC + 2)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NSRC*WIDTH-1:0] src_flat,
   input  logic [SELW-1:0]       sel,
   input  logic                  hold_en,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SELW-1:0]       out_sel,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  err_clr,
   output logic                  sel_err
);

   localparam logic [SELW-1:0] SEL_AUX  = SELW'(sel_aux_code(NSRC));
   localparam logic [SELW-1:0] SEL_ZERO = SELW'(sel_zero_code(NSRC));

   logic [WIDTH-1:0]      aux_q, aux_d;
   logic                  sel_err_q, sel_err_d;
   logic [WIDTH-1:0]      sel_val;
   logic                  sel_bad;
   logic                  accept;
   logic [SELW+WIDTH-1:0] buf_out;

   assign accept = in_valid && in_ready;

   // Out-of-range codes fall through to the zero default.
   always_comb begin
      sel_val = '0;
      sel_bad = 1'b0;
      if (sel == SEL_AUX) begin
         sel_val = aux_q;
      end else if (sel == SEL_ZERO) begin
         sel_val = '0;
      end else if (sel > SEL_ZERO) begin
         sel_bad = 1'b1;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (sel == SELW'(i)) sel_val = src_flat[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      aux_d     = aux_q;
      sel_err_d = sel_err_q;
      if (accept && hold_en) aux_d = sel_val;
      if (err_clr) sel_err_d = 1'b0;
      // A new error in the same cycle as a clear must not be lost.
      if (accept && sel_bad) sel_err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aux_q     <= '0;
         sel_err_q <= 1'b0;
      end else begin
         aux_q     <= aux_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign sel_err = sel_err_q;

   skid_buf #(.DW(WIDTH + SELW)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_data   ({sel, sel_val}),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (buf_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign out_sel  = buf_out[SELW+WIDTH-1:WIDTH];
   assign out_data = buf_out[WIDTH-1:0];

endmodule

// File: tb/tb_alu_src_stage.sv
module tb_alu_src_stage;

   localparam int WIDTH = 32;
   localparam int NSRC  = 4;
   localparam int SELW  = 3;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NSRC*WIDTH-1:0] src_flat;
   logic [SELW-1:0]       sel;
   logic                  hold_en;
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      out_data;
   logic [SELW-1:0]       out_sel;
   logic                  out_valid;
   logic                  out_ready;
   logic                  err_clr;
   logic                  sel_err;

   alu_src_stage #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (
      .clk       (clk),
      .reset     (reset),
      .src_flat  (src_flat),
      .sel       (sel),
      .hold_en   (hold_en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err_clr   (err_clr),
      .sel_err   (sel_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic [SELW-1:0]  s;
   } exp_t;

   typedef struct {
      logic [SELW-1:0]  sel;
      logic             hold;
      logic [WIDTH-1:0] exp_d;
      logic             exp_err;
   } vec_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_out    = 0;
   int   n_acc    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_sources();
      for (int i = 0; i < NSRC; i++) src_flat[i*WIDTH +: WIDTH] = (WIDTH'(i) + 1) * 32'h11111111;
   endtask

   // Scoreboard side: every drain seen before the edge is compared in order.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%0h sel %0d, expected nothing", out_data, out_sel);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", {32'd0, out_data}, {32'd0, e.d});
            check("out_sel", {61'd0, out_sel}, {61'd0, e.s});
         end
         n_out++;
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic req(input logic [SELW-1:0] sv, input logic h, input logic c,
                      input logic [WIDTH-1:0] ed);
      bit done = 0;
      int waited = 0;
      sel = sv; hold_en = h; err_clr = c; in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{d: ed, s: sv});
            n_acc++;
            done = 1;
         end
         @(posedge clk); #1;
         waited++;
         if (!done && waited > 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: got in_ready 0 for %0d cycles, expected 1", waited);
            done = 1;
         end
      end
      hold_en = 1'b0; err_clr = 1'b0;
   endtask

   task automatic idle(input logic c);
      in_valid = 1'b0; err_clr = c;
      @(posedge clk); #1;
      err_clr = 1'b0;
   endtask

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{3'd2, 1'b0, 32'h33333333, 1'b0};
      vecs[1]  = '{3'd1, 1'b1, 32'h22222222, 1'b0};
      vecs[2]  = '{3'd4, 1'b0, 32'h22222222, 1'b0};
      vecs[3]  = '{3'd5, 1'b0, 32'h00000000, 1'b0};
      vecs[4]  = '{3'd4, 1'b1, 32'h22222222, 1'b0};
      vecs[5]  = '{3'd0, 1'b0, 32'h11111111, 1'b0};
      vecs[6]  = '{3'd3, 1'b0, 32'h44444444, 1'b0};
      vecs[7]  = '{3'd7, 1'b0, 32'h00000000, 1'b1};
      vecs[8]  = '{3'd5, 1'b0, 32'h00000000, 1'b1};
      vecs[9]  = '{3'd6, 1'b0, 32'h00000000, 1'b1};
      vecs[10] = '{3'd4, 1'b0, 32'h22222222, 1'b1};

      reset = 1'b1; sel = '0; hold_en = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; err_clr = 1'b0;
      set_sources();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_data", {32'd0, out_data}, 64'd0);
      check("rst_out_sel", {61'd0, out_sel}, 64'd0);
      check("rst_sel_err", {63'd0, sel_err}, 64'd0);
      reset = 1'b0;
      out_ready = 1'b1;

      // Table of single requests with free-flowing output.
      for (int i = 0; i < 11; i++) begin
         req(vecs[i].sel, vecs[i].hold, 1'b0, vecs[i].exp_d);
         if (i == 0) begin
            check("first_out_valid", {63'd0, out_valid}, 64'd1);
            check("first_out_data", {32'd0, out_data}, 64'h33333333);
         end
         check("vec_sel_err", {63'd0, sel_err}, {63'd0, vecs[i].exp_err});
      end
      idle(1'b0);

      // Sticky error: clear, then clear together with a new bad select.
      idle(1'b1);
      check("err_cleared", {63'd0, sel_err}, 64'd0);
      req(3'd7, 1'b0, 1'b1, 32'h0);
      check("err_set_wins", {63'd0, sel_err}, 64'd1);
      idle(1'b0);
      check("err_sticky", {63'd0, sel_err}, 64'd1);
      idle(1'b1);
      check("err_cleared2", {63'd0, sel_err}, 64'd0);
      repeat (2) idle(1'b0);

      // Backpressure: two accepts fill the buffer, third request must wait.
      out_ready = 1'b0;
      req(3'd0, 1'b0, 1'b0, 32'h11111111);
      req(3'd1, 1'b0, 1'b0, 32'h22222222);
      check("full_in_ready", {63'd0, in_ready}, 64'd0);
      check("full_out_valid", {63'd0, out_valid}, 64'd1);
      sel = 3'd2; in_valid = 1'b1;
      src_flat = {NSRC{32'hDEADBEEF}};
      repeat (3) @(posedge clk);
      #1;
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_out_data", {32'd0, out_data}, 64'h11111111);
      check("stall_out_sel", {61'd0, out_sel}, 64'd0);
      set_sources();
      out_ready = 1'b1;
      req(3'd2, 1'b0, 1'b0, 32'h33333333);
      repeat (3) idle(1'b0);
      check("bp_sb_empty", 64'(sb.size()), 64'd0);
      check("bp_no_loss", 64'(n_out), 64'(n_acc));

      // Streaming: accept and drain every cycle.
      for (int i = 0; i < 10; i++) begin
         logic [SELW-1:0]  sv;
         logic [WIDTH-1:0] e;
         sv = SELW'($urandom_range(0, 3));
         e = (WIDTH'(sv) + 32'd1) * 32'h11111111;
         req(sv, 1'b0, 1'b0, e);
         check("stream_out_valid", {63'd0, out_valid}, 64'd1);
         check("stream_in_ready", {63'd0, in_ready}, 64'd1);
         check("stream_delay1", {32'd0, out_data}, {32'd0, e});
      end
      repeat (3) idle(1'b0);
      check("stream_no_loss", 64'(n_out), 64'(n_acc));

      // Reset while FULL with aux loaded and error set.
      out_ready = 1'b0;
      req(3'd7, 1'b0, 1'b0, 32'h0);
      req(3'd1, 1'b1, 1'b0, 32'h22222222);
      in_valid = 1'b0;
      check("pre_rst_err", {63'd0, sel_err}, 64'd1);
      check("pre_rst_full", {63'd0, in_ready}, 64'd0);
      #2 reset = 1'b1;
      #1;
      check("arst_out_valid", {63'd0, out_valid}, 64'd0);
      check("arst_in_ready", {63'd0, in_ready}, 64'd1);
      check("arst_sel_err", {63'd0, sel_err}, 64'd0);
      check("arst_out_data", {32'd0, out_data}, 64'd0);
      sb.delete();
      n_acc = n_out;
      @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      req(3'd4, 1'b0, 1'b0, 32'h0);
      repeat (3) idle(1'b0);
      check("final_sb_empty", 64'(sb.size()), 64'd0);
      check("final_no_loss", 64'(n_out), 64'(n_acc));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, expected completion");
      $fatal(1, "timeout");
   end

endmodule
